// File: rtl/stream_replay_source.sv
// stream_replay_source: RAM-backed frame replayer driving a vld/rdy/fst sample stream.
module stream_replay_source #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   cfg_length,
  input  logic [15:0]       cfg_frames,
  input  logic              start,
  input  logic              abort,
  output logic [DATA_W-1:0] out_data,
  output logic              out_fst,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_count
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned FC_W  = 16;
  localparam int unsigned FCX_W = FC_W + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [FC_W-1:0]   nfr_q, nfr_d;
  logic [FC_W-1:0]   frame_count_q, frame_count_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_fst_q, out_fst_d;
  logic              out_vld_q, out_vld_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              xfer_c;
  logic              last_c;
  logic              len_ok_c;
  logic [FCX_W-1:0]  fc_inc_c;
  logic [ADDR_W-1:0] rd_addr_c;
  logic [DATA_W-1:0] rd_data_c;

  // Frame RAM write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Handshake, frame-end and next-read-address decode
  always_comb begin
    xfer_c    = out_vld_q & out_rdy;
    last_c    = ({1'b0, addr_q} == (len_q - LEN_W'(1)));
    len_ok_c  = (cfg_length != '0) && (cfg_length <= DEPTH_L);
    fc_inc_c  = {1'b0, frame_count_q} + FCX_W'(1);
    rd_addr_c = ((state_q != S_RUN) || last_c) ? '0 : (addr_q + ADDR_W'(1));
  end

  // RAM read with same-cycle write forwarding so a fresh write is never missed
  always_comb begin
    rd_data_c = mem[rd_addr_c];
    if (wr_en && (wr_addr == rd_addr_c)) begin
      rd_data_c = wr_data;
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    nfr_d         = nfr_q;
    frame_count_d = frame_count_q;
    out_data_d    = out_data_q;
    out_fst_d     = out_fst_q;
    out_vld_d     = out_vld_q;
    done_d        = 1'b0;

    if (abort) begin
      state_d   = S_IDLE;
      out_vld_d = 1'b0;
      out_fst_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && len_ok_c) begin
            state_d       = S_RUN;
            len_d         = cfg_length;
            nfr_d         = cfg_frames;
            addr_d        = '0;
            frame_count_d = '0;
            out_data_d    = rd_data_c;
            out_fst_d     = 1'b1;
            out_vld_d     = 1'b1;
          end
        end
        S_RUN: begin
          if (xfer_c) begin
            out_data_d = rd_data_c;
            if (last_c) begin
              addr_d = '0;
              if (frame_count_q != '1) begin
                frame_count_d = fc_inc_c[FC_W-1:0];
              end
              if ((nfr_q != '0) && (fc_inc_c == {1'b0, nfr_q})) begin
                state_d    = S_DONE;
                out_vld_d  = 1'b0;
                out_fst_d  = 1'b0;
                out_data_d = out_data_q;
                done_d     = 1'b1;
              end else begin
                out_fst_d = 1'b1;
              end
            end else begin
              addr_d    = addr_q + ADDR_W'(1);
              out_fst_d = 1'b0;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      nfr_q         <= '0;
      frame_count_q <= '0;
      out_data_q    <= '0;
      out_fst_q     <= 1'b0;
      out_vld_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      nfr_q         <= nfr_d;
      frame_count_q <= frame_count_d;
      out_data_q    <= out_data_d;
      out_fst_q     <= out_fst_d;
      out_vld_q     <= out_vld_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_fst     = out_fst_q;
  assign out_vld     = out_vld_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_stream_replay_source.sv
// Bench for stream_replay_source: table-driven replays plus abort/reset/illegal-config sequences.
module tb_stream_replay_source;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   cfg_length;
  logic [15:0]       cfg_frames;
  logic              start;
  logic              abort;
  logic [DATA_W-1:0] out_data;
  logic              out_fst;
  logic              out_vld;
  logic              out_rdy;
  logic              busy;
  logic              done;
  logic [15:0]       frame_count;

  stream_replay_source #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cfg_length(cfg_length), .cfg_frames(cfg_frames), .start(start), .abort(abort),
    .out_data(out_data), .out_fst(out_fst), .out_vld(out_vld), .out_rdy(out_rdy),
    .busy(busy), .done(done), .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              fst;
  } samp_t;

  typedef struct {
    int len;
    int frames;
    int pat;
    int exp_k;
    int exp_fc;
  } vec_t;

  samp_t             sbq[$];
  logic [DATA_W-1:0] model_mem [DEPTH];
  vec_t              vecs [5];

  int n_cmp = 0;
  int n_bad = 0;
  int xfers = 0;
  int dones = 0;
  logic              stall_prev = 1'b0;
  logic              exempt_prev = 1'b0;
  logic [DATA_W-1:0] held_data = '0;
  logic              held_fst = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive rdy, score the outputs visible before the edge, advance to edge+1
  task automatic cyc(input logic rdy);
    samp_t e;
    out_rdy = rdy;
    if (stall_prev && !exempt_prev) check("vld_hold", 64'(out_vld), 64'(1));
    if (stall_prev && out_vld) begin
      check("stall_data", 64'(out_data), 64'(held_data));
      check("stall_fst", 64'(out_fst), 64'(held_fst));
    end
    if (out_vld && rdy) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: got data %0h with no expected sample", out_data);
      end else begin
        e = sbq.pop_front();
        check("data", 64'(out_data), 64'(e.data));
        check("fst", 64'(out_fst), 64'(e.fst));
      end
      xfers++;
    end
    if (done) dones++;
    stall_prev  = out_vld && !rdy;
    held_data   = out_data;
    held_fst    = out_fst;
    exempt_prev = abort || reset;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [DATA_W-1:0] d);
    wr_en     = 1'b1;
    wr_addr   = ADDR_W'(a);
    wr_data   = d;
    model_mem[a] = d;
    cyc(1'b0);
    wr_en     = 1'b0;
  endtask

  task automatic push_frames(input int len, input int nsamp);
    samp_t s;
    for (int i = 0; i < nsamp; i++) begin
      s.data = model_mem[i % len];
      s.fst  = ((i % len) == 0);
      sbq.push_back(s);
    end
  endtask

  // Start a finite replay and run to its done pulse
  task automatic run_cfg(input vec_t v);
    int  k;
    int  done_k;
    logic rdy;
    k      = 0;
    done_k = -1;
    dones  = 0;
    push_frames(v.len, v.len * v.frames);
    cfg_length = 7'(v.len);
    cfg_frames = 16'(v.frames);
    start = 1'b1;
    cyc(1'b0);
    start = 1'b0;
    cfg_length = 7'd3;
    cfg_frames = 16'd9;
    check("busy_after_start", 64'(busy), 64'(1));
    while (done_k < 0 && k < 2000) begin
      rdy = (v.pat == 0) ? 1'b1 : ((k % 4) == 0 || (k % 4) == 3);
      if (done) done_k = k;
      cyc(rdy);
      k++;
    end
    check("done_cycle", 64'(done_k), 64'(v.exp_k));
    check("done_count", 64'(dones), 64'(1));
    check("frame_count", 64'(frame_count), 64'(v.exp_fc));
    check("sb_empty", 64'(sbq.size()), 64'(0));
    check("busy_after_done", 64'(busy), 64'(0));
    check("done_low", 64'(done), 64'(0));
    sbq.delete();
  endtask

  initial begin
    int base;
    int k;

    vecs[0] = '{len: 5,  frames: 2, pat: 0, exp_k: 10, exp_fc: 2};
    vecs[1] = '{len: 5,  frames: 2, pat: 1, exp_k: 20, exp_fc: 2};
    vecs[2] = '{len: 1,  frames: 3, pat: 0, exp_k: 3,  exp_fc: 3};
    vecs[3] = '{len: 64, frames: 1, pat: 0, exp_k: 64, exp_fc: 1};
    vecs[4] = '{len: 3,  frames: 2, pat: 1, exp_k: 12, exp_fc: 2};

    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    cfg_length = '0; cfg_frames = '0; start = 1'b0; abort = 1'b0; out_rdy = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    reset = 1'b0;
    check("rst_vld", 64'(out_vld), 64'(0));
    check("rst_fst", 64'(out_fst), 64'(0));
    check("rst_data", 64'(out_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_fc", 64'(frame_count), 64'(0));

    for (int i = 0; i < int'(DEPTH); i++) wr(i, 32'h3F80_0000 + 32'(i));

    for (int v = 0; v < 5; v++) run_cfg(vecs[v]);

    // Freshly written word must be replayed
    wr(0, 32'hDEAD_BEEF);
    run_cfg('{len: 2, frames: 1, pat: 0, exp_k: 2, exp_fc: 1});

    // Illegal lengths are ignored
    cfg_length = 7'd0; cfg_frames = 16'd1; start = 1'b1;
    cyc(1'b1);
    start = 1'b0;
    check("len0_busy", 64'(busy), 64'(0));
    check("len0_vld", 64'(out_vld), 64'(0));
    cfg_length = 7'd65; start = 1'b1;
    cyc(1'b1);
    start = 1'b0;
    check("len65_busy", 64'(busy), 64'(0));
    check("len65_vld", 64'(out_vld), 64'(0));

    // Start and abort together: abort wins
    cfg_length = 7'd4; start = 1'b1; abort = 1'b1;
    cyc(1'b1);
    start = 1'b0; abort = 1'b0;
    check("startabort_busy", 64'(busy), 64'(0));
    check("startabort_vld", 64'(out_vld), 64'(0));

    // Infinite replay of 36, 100 transfers, then abort
    dones = 0;
    push_frames(36, 100);
    cfg_length = 7'd36; cfg_frames = 16'd0; start = 1'b1;
    cyc(1'b0);
    start = 1'b0;
    base = xfers;
    k = 0;
    while ((xfers - base) < 100 && k < 400) begin
      cyc(1'b1);
      k++;
    end
    check("inf_xfers", 64'(xfers - base), 64'(100));
    check("inf_fc", 64'(frame_count), 64'(2));
    abort = 1'b1;
    cyc(1'b0);
    abort = 1'b0;
    check("abort_vld", 64'(out_vld), 64'(0));
    check("abort_fst", 64'(out_fst), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_fc", 64'(frame_count), 64'(2));
    cyc(1'b1);
    cyc(1'b1);
    check("abort_no_done", 64'(dones), 64'(0));
    check("inf_sb_empty", 64'(sbq.size()), 64'(0));
    sbq.delete();

    // Reset while stalled on sample 3 of the second frame
    push_frames(5, 8);
    cfg_length = 7'd5; cfg_frames = 16'd0; start = 1'b1;
    cyc(1'b0);
    start = 1'b0;
    for (int i = 0; i < 8; i++) cyc(1'b1);
    cyc(1'b0);
    check("pre_rst_fc", 64'(frame_count), 64'(1));
    check("pre_rst_data", 64'(out_data), 64'(model_mem[3]));
    reset = 1'b1;
    cyc(1'b0);
    reset = 1'b0;
    check("midrst_vld", 64'(out_vld), 64'(0));
    check("midrst_fc", 64'(frame_count), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_data", 64'(out_data), 64'(0));
    check("midrst_sb_empty", 64'(sbq.size()), 64'(0));
    sbq.delete();
    run_cfg('{len: 5, frames: 1, pat: 0, exp_k: 5, exp_fc: 1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
